// File: rtl/divisor_pkg.sv
// Shared constants and the divide-ratio clamp
// used by divisor_tick and its event capture.
package divisor_pkg;

  localparam logic [31:0] DIV_MIN = 32'd2;

  localparam int WIDTH_DEF = 25;
  localparam int DIV_DEF   = 25_000_000;
  localparam int N_EV_DEF  = 2;

  // Ratios 0 and 1 make no sense for a counter
  // period; they load as the shortest period.
  function automatic logic [31:0] div_clamp(
    input logic [31:0] v
  );
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

endpackage

// File: rtl/divisor_ev_capture.sv
// One event channel: optional 2-flop sync, window flag, held result.
// Ports: clk, rst_n, ev_in, clr, close -> ev_seen (Mealy), ev_hold.
import divisor_pkg::*;

module divisor_ev_capture (
  input  logic clk,
  input  logic rst_n,
  input  logic ev_in,
  input  logic clr,
  input  logic close,
  output logic ev_seen,
  output logic ev_hold
);

  logic ev_s;
  logic ev_flag;

`ifdef DIVISOR_TICK_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], ev_in};
    end
  end

  assign ev_s = sync[1];
`else
  assign ev_s = ev_in;
`endif

  // An event in the closing cycle lands in
  // the window being closed, not the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_flag <= 1'b0;
      ev_hold <= 1'b0;
    end else if (clr) begin
      ev_flag <= 1'b0;
    end else if (close) begin
      ev_hold <= ev_flag | ev_s;
      ev_flag <= 1'b0;
    end else begin
      ev_flag <= ev_flag | ev_s;
    end
  end

  assign ev_seen = ev_flag | ev_s;

endmodule

// File: rtl/divisor_tick.sv
// Single-clock divider: loadable ratio, tick enable, square wave,
// per-window event capture. Option macro: DIVISOR_TICK_SYNC_EN.
// Ports: clk, rst_n, en, div_load, div_val, ev_in
//        -> tick, clk_slow, ev_seen, ev_hold.
import divisor_pkg::*;

module divisor_tick #(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DIV_DEFAULT = DIV_DEF,
  parameter int N_EV        = N_EV_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            div_load,
  input  logic [WIDTH-1:0] div_val,
  input  logic [N_EV-1:0] ev_in,
  output logic            tick,
  output logic            clk_slow,
  output logic [N_EV-1:0] ev_seen,
  output logic [N_EV-1:0] ev_hold
);

  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_nx;
  logic [WIDTH-1:0] cnt_nx;
  logic             tick_nx;
  logic             wrap;

  assign wrap = (cnt == div_r - WIDTH'(1));

  always_comb begin
    div_nx  = div_r;
    cnt_nx  = cnt;
    tick_nx = 1'b0;
    if (div_load) begin
      div_nx = WIDTH'(div_clamp(32'(div_val)));
      cnt_nx = '0;
    end else if (en) begin
      cnt_nx  = wrap ? '0 : cnt + WIDTH'(1);
      tick_nx = wrap;
    end
  end

  // clk_slow is computed from next-state values
  // so it stays aligned with cnt with no glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r    <= WIDTH'(DIV_DEFAULT);
      cnt      <= '0;
      tick     <= 1'b0;
      clk_slow <= 1'b0;
    end else begin
      div_r    <= div_nx;
      cnt      <= cnt_nx;
      tick     <= tick_nx;
      clk_slow <= (cnt_nx >= (div_nx >> 1));
    end
  end

  for (genvar i = 0; i < N_EV; i++) begin : g_ev
    divisor_ev_capture u_ev (
      .clk     (clk),
      .rst_n   (rst_n),
      .ev_in   (ev_in[i]),
      .clr     (div_load),
      .close   (tick_nx),
      .ev_seen (ev_seen[i]),
      .ev_hold (ev_hold[i])
    );
  end

endmodule

// File: tb/tb_divisor_tick.sv
// Bench for divisor_tick: directed steps plus random
// stimulus against a modular-arithmetic reference model.
module tb_divisor_tick;

  localparam int W  = 8;
  localparam int DD = 10;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         div_load;
  logic [W-1:0] div_val;
  logic [1:0]   ev_in;
  logic         tick;
  logic         clk_slow;
  logic [1:0]   ev_seen;
  logic [1:0]   ev_hold;

  divisor_tick #(
    .WIDTH       (W),
    .DIV_DEFAULT (DD),
    .N_EV        (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_load (div_load),
    .div_val  (div_val),
    .ev_in    (ev_in),
    .tick     (tick),
    .clk_slow (clk_slow),
    .ev_seen  (ev_seen),
    .ev_hold  (ev_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  int         div_m;
  int         k;
  logic [1:0] flag_m;
  logic [1:0] hold_m;
  logic [1:0] h0;
  logic [1:0] h1;
  logic       tick_m;

  int         cyc_n;
  int         last_tk;
  int         intv;
  logic [1:0] seen_obs;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, o, e);
    end
  endtask

  task automatic model_reset();
    div_m  = DD;
    k      = 0;
    flag_m = 2'b00;
    hold_m = 2'b00;
    h0     = 2'b00;
    h1     = 2'b00;
    tick_m = 1'b0;
  endtask

  function automatic logic [1:0] ev_src(
    input logic [1:0] ev
  );
`ifdef DIVISOR_TICK_SYNC_EN
    return h1;
`else
    return ev;
`endif
  endfunction

  // One clock: drive at negedge, check Mealy output,
  // step the model on posedge, check registers at negedge.
  task automatic cyc(input logic e,
                     input logic ld,
                     input logic [W-1:0] v,
                     input logic [1:0] ev);
    logic [1:0] es;
    en       = e;
    div_load = ld;
    div_val  = v;
    ev_in    = ev;
    es       = ev_src(ev);
    #1;
    seen_obs = ev_seen;
    chk("ev_seen", 32'(ev_seen), 32'(flag_m | es));
    @(posedge clk);
    if (ld) begin
      div_m  = (v < 2) ? 2 : int'(v);
      k      = 0;
      tick_m = 1'b0;
      flag_m = 2'b00;
    end else begin
      tick_m = e && ((k % div_m) == div_m - 1);
      if (e) k = k + 1;
      if (tick_m) begin
        hold_m = flag_m | es;
        flag_m = 2'b00;
      end else begin
        flag_m = flag_m | es;
      end
    end
    h1 = h0;
    h0 = ev;
    @(negedge clk);
    cyc_n++;
    if (tick) begin
      intv    = cyc_n - last_tk;
      last_tk = cyc_n;
    end
    chk("tick", 32'(tick), 32'(tick_m));
    chk("clk_slow", 32'(clk_slow),
        32'((k % div_m) >= (div_m / 2)));
    chk("ev_hold", 32'(ev_hold), 32'(hold_m));
    chk("cnt", 32'(dut.cnt), 32'(k % div_m));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, 2'b00);
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    div_load = 1'b0;
    div_val  = '0;
    ev_in    = 2'b00;
    cyc_n    = 0;
    last_tk  = 0;
    intv     = 0;
    seen_obs = 2'b00;
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_slow", 32'(clk_slow), 32'd0);
    chk("rst_hold", 32'(ev_hold), 32'd0);
    chk("rst_cnt", 32'(dut.cnt), 32'd0);
    chk("rst_div", 32'(dut.div_r), 32'(DD));

    // default ratio straight out of reset
    run(22);
    chk("def_intv", 32'(intv), 32'(DD));

    // ratio 4
    cyc(1'b1, 1'b1, W'(4), 2'b00);
    run(12);
    chk("r4_intv", 32'(intv), 32'd4);

    // ratio 5, then 0 and 1 both clamp to 2
    cyc(1'b1, 1'b1, W'(5), 2'b00);
    run(10);
    chk("r5_intv", 32'(intv), 32'd5);
    cyc(1'b1, 1'b1, W'(0), 2'b00);
    run(6);
    chk("r0_intv", 32'(intv), 32'd2);
    chk("r0_div", 32'(dut.div_r), 32'd2);
    cyc(1'b1, 1'b1, W'(1), 2'b00);
    run(6);
    chk("r1_intv", 32'(intv), 32'd2);

    // ratio 6 with a 3-cycle enable gap at cnt=2
    cyc(1'b1, 1'b1, W'(6), 2'b00);
    run(8);
    chk("gap_cnt", 32'(dut.cnt), 32'd2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 2'b00);
    chk("gap_hold", 32'(dut.cnt), 32'd2);
    run(4);
    chk("gap_intv", 32'(intv), 32'd9);

    // ratio 8 events: ch0 mid-window, ch1 in closing cycle
    cyc(1'b1, 1'b1, W'(8), 2'b00);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, '0,
          (i == 3) ? 2'b01 : (i == 7) ? 2'b10 : 2'b00);
`ifndef DIVISOR_TICK_SYNC_EN
    chk("win_hold", 32'(ev_hold), 32'h3);
`endif
    run(10);
    chk("win_empty", 32'(ev_hold), 32'h0);

    // async reset at cnt=5 with a pending flag
    cyc(1'b1, 1'b1, W'(8), 2'b00);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, '0, (i == 2) ? 2'b01 : 2'b00);
    run(2);
    cyc(1'b1, 1'b0, '0, 2'b01);
    run(2);
    chk("pre_cnt", 32'(dut.cnt), 32'd5);
    en    = 1'b0;
    ev_in = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cnt", 32'(dut.cnt), 32'd0);
    chk("ar_tick", 32'(tick), 32'd0);
    chk("ar_slow", 32'(clk_slow), 32'd0);
    chk("ar_hold", 32'(ev_hold), 32'd0);
    chk("ar_div", 32'(dut.div_r), 32'(DD));
    chk("ar_seen", 32'(ev_seen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // ev_seen latency from a 1-cycle pulse
    cyc(1'b1, 1'b1, W'(20), 2'b00);
    run(2);
    cyc(1'b1, 1'b0, '0, 2'b01);
`ifdef DIVISOR_TICK_SYNC_EN
    chk("lat_t0", 32'(seen_obs), 32'd0);
    run(1);
    chk("lat_t1", 32'(seen_obs), 32'd0);
    run(1);
    chk("lat_t2", 32'(seen_obs), 32'd1);
`else
    chk("lat_t0", 32'(seen_obs), 32'd1);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0] ev;
      ev[0] = ($urandom_range(0, 7) == 0);
      ev[1] = ($urandom_range(0, 7) == 0);
      cyc($urandom_range(0, 5) != 0,
          $urandom_range(0, 24) == 0,
          W'($urandom_range(0, 12)),
          ev);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
